// File: rtl/isa_pkg.sv
// Shared constants for the ISA I/O front end: default decode windows, FSM states, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package isa_pkg;

    localparam logic [15:0] DEF_JOY_ADDR = 16'h0201;
    localparam logic [15:0] DEF_SB_BASE  = 16'h0220;
    localparam logic [15:0] DEF_FM_BASE  = 16'h0388;
    localparam logic [15:0] DEF_MPU_BASE = 16'h0330;

    localparam logic [15:0] SB_SPAN  = 16'd16;
    localparam logic [15:0] FM_SPAN  = 16'd4;
    localparam logic [15:0] MPU_SPAN = 16'd2;

    // FSM state encoding, kept as plain constants so legacy tools can share it
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_ERR   = 2'd3;

    // True when addr lies in [base, base+size); widened so a window at the top of the map cannot wrap
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                       input logic [15:0] size);
        logic [16:0] lim;
        lim = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/isa_io_frontend_if.sv
// Bundle of raw ISA bus inputs and decoded device-side outputs of the front end.
// Latency: n/a (wiring only).
// Backpressure: none; the ISA bus cannot be stalled from this side.
interface isa_io_frontend_if;
    logic [15:0] SA;
    logic        BALE;
    logic        AEN;
    logic        IOR_N;
    logic        IOW_N;
    logic        SBHE;
    logic [15:0] SD_IN;

    logic [15:0] io_addr;
    logic        joy_cs;
    logic        sb_cs;
    logic        fm_cs;
    logic        mpu_cs;
    logic        rd_strobe;
    logic        wr_strobe;
    logic [7:0]  wr_data;
    logic        sd_drive;
    logic        cmd_err;

    modport slave (
        input  SA, BALE, AEN, IOR_N, IOW_N, SBHE, SD_IN,
        output io_addr, joy_cs, sb_cs, fm_cs, mpu_cs, rd_strobe, wr_strobe, wr_data, sd_drive, cmd_err
    );

    modport master (
        output SA, BALE, AEN, IOR_N, IOW_N, SBHE, SD_IN,
        input  io_addr, joy_cs, sb_cs, fm_cs, mpu_cs, rd_strobe, wr_strobe, wr_data, sd_drive, cmd_err
    );
endinterface

// File: rtl/isa_sync.sv
// N-stage single-bit synchronizer with a selectable reset level.
// Latency: N clk cycles.
// Backpressure: none.
module isa_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    // Shift the asynchronous input through N flops; reset loads the inactive level
    always_ff @(posedge clk_i) begin
        if (!rst_ni) sync_q <= {N{RST_VAL}};
        else         sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/isa_io_frontend.sv
// ISA I/O front end: synchronizes the bus, latches/decodes the address, issues single-cycle rd/wr strobes.
// Latency: ISA command edge to strobe = 3 cycles, 4 with ISA_GLITCH_FILTER_EN (3-sample IOR/IOW majority filter).
// Backpressure: none; strobes are fire-and-forget, DMA cycles (AEN) and IOR+IOW collisions are suppressed.
module isa_io_frontend
    import isa_pkg::*;
#(
    parameter logic [15:0] JOY_ADDR = DEF_JOY_ADDR,
    parameter logic [15:0] SB_BASE  = DEF_SB_BASE,
    parameter logic [15:0] FM_BASE  = DEF_FM_BASE,
    parameter logic [15:0] MPU_BASE = DEF_MPU_BASE
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    isa_io_frontend_if.slave   bus
);
    logic        bale_s, aen_s, ior_raw_s, iow_raw_s, ior_s, iow_s;
    logic [15:0] sa_q, sd_q;
    logic        sbhe_q;
    logic        bale_prev_q;
    logic [15:0] io_addr_q;
    logic [3:0]  cs_dec_d, cs_dec_q, cs_vec;
    logic        cs_any;
    state_t      state_q, state_d;
    logic        rd_fire, wr_fire;
    logic        rd_strobe_q, wr_strobe_q, cmd_err_q, wr_aen_q, armed_q;
    logic [7:0]  wr_data_q;
    logic [3:0]  settle_q;

    isa_sync #(.N(2), .RST_VAL(1'b0)) u_sync_bale (.clk_i(clk_sys), .rst_ni(rst_n), .d_i(bus.BALE),  .q_o(bale_s));
    isa_sync #(.N(2), .RST_VAL(1'b1)) u_sync_aen  (.clk_i(clk_sys), .rst_ni(rst_n), .d_i(bus.AEN),   .q_o(aen_s));
    isa_sync #(.N(2), .RST_VAL(1'b1)) u_sync_ior  (.clk_i(clk_sys), .rst_ni(rst_n), .d_i(bus.IOR_N), .q_o(ior_raw_s));
    isa_sync #(.N(2), .RST_VAL(1'b1)) u_sync_iow  (.clk_i(clk_sys), .rst_ni(rst_n), .d_i(bus.IOW_N), .q_o(iow_raw_s));

`ifdef ISA_GLITCH_FILTER_EN
    logic [1:0] ior_hist_q, iow_hist_q;

    // Keep the two previous synchronized command samples for the majority vote
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            ior_hist_q <= 2'b11;
            iow_hist_q <= 2'b11;
        end else begin
            ior_hist_q <= {ior_hist_q[0], ior_raw_s};
            iow_hist_q <= {iow_hist_q[0], iow_raw_s};
        end
    end

    assign ior_s = maj3(ior_raw_s, ior_hist_q[0], ior_hist_q[1]);
    assign iow_s = maj3(iow_raw_s, iow_hist_q[0], iow_hist_q[1]);
`else
    assign ior_s = ior_raw_s;
    assign iow_s = iow_raw_s;
`endif

    // Address, data and byte-high-enable only need a single capture flop; they are qualified by synced controls
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sd_q   <= '0;
            sbhe_q <= 1'b1;
        end else begin
            sa_q   <= bus.SA;
            sd_q   <= bus.SD_IN;
            sbhe_q <= bus.SBHE;
        end
    end

    // Latch the I/O address when synchronized BALE falls
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            bale_prev_q <= 1'b0;
            io_addr_q   <= '0;
        end else begin
            bale_prev_q <= bale_s;
            if (bale_prev_q && !bale_s) io_addr_q <= sa_q;
        end
    end

    // Priority decode keeps the chip selects one-hot even with overlapping parameter overrides
    always_comb begin
        cs_dec_d = '0;
        if (io_addr_q == JOY_ADDR)                     cs_dec_d[0] = 1'b1;
        else if (in_window(io_addr_q, SB_BASE, SB_SPAN))   cs_dec_d[1] = 1'b1;
        else if (in_window(io_addr_q, FM_BASE, FM_SPAN))   cs_dec_d[2] = 1'b1;
        else if (in_window(io_addr_q, MPU_BASE, MPU_SPAN)) cs_dec_d[3] = 1'b1;
    end

    // Register the window decode one cycle after the address latch
    always_ff @(posedge clk_sys) begin
        if (!rst_n) cs_dec_q <= '0;
        else        cs_dec_q <= cs_dec_d;
    end

    // A DMA cycle masks every select immediately
    assign cs_vec = cs_dec_q & {4{!aen_s}};
    assign cs_any = |cs_vec;

    // Command FSM; nothing leaves IDLE until both commands have been seen high after reset
    always_comb begin
        state_d = state_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q) begin
                    if (!ior_s && !iow_s) state_d = ST_ERR;
                    else if (!ior_s) begin
                        state_d = ST_READ;
                        rd_fire = cs_any;
                    end else if (!iow_s) state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (!ior_s && !iow_s) state_d = ST_ERR;
                else if (ior_s)       state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (!ior_s && !iow_s) state_d = ST_ERR;
                else if (iow_s) begin
                    state_d = ST_IDLE;
                    wr_fire = cs_any && !wr_aen_q;
                end
            end
            ST_ERR: begin
                if (ior_s && iow_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, strobes, error flag, write-data capture and the post-reset arming logic
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_aen_q    <= 1'b0;
            wr_data_q   <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_strobe_q <= rd_fire;
            wr_strobe_q <= wr_fire;
            cmd_err_q   <= cmd_err_q | (state_d == ST_ERR);
            // AEN seen at any point of a write cancels its strobe
            wr_aen_q    <= (state_q == ST_WRITE) ? (wr_aen_q | aen_s) : 1'b0;
            if (state_d == ST_WRITE)
                wr_data_q <= (!sbhe_q && io_addr_q[0]) ? sd_q[15:8] : sd_q[7:0];
            // Wait until the sync/filter pipeline holds real bus levels before trusting "both high"
            settle_q    <= {settle_q[2:0], 1'b1};
            if (settle_q[3] && ior_s && iow_s) armed_q <= 1'b1;
        end
    end

    assign bus.io_addr   = io_addr_q;
    assign bus.joy_cs    = cs_vec[0];
    assign bus.sb_cs     = cs_vec[1];
    assign bus.fm_cs     = cs_vec[2];
    assign bus.mpu_cs    = cs_vec[3];
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.sd_drive  = (state_q == ST_READ) && cs_any;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: doc/isa_io_frontend.md
ISA_IO_FRONTEND -- requirements
Module: isa_io_frontend

Interface
REQ-001 SHALL have parameter JOY_ADDR, default 16'h0201, joystick port address.
REQ-002 SHALL have parameter SB_BASE, default 16'h0220, Sound Blaster window base; window is SB_BASE..SB_BASE+15.
REQ-003 SHALL have parameter FM_BASE, default 16'h0388, OPL window base; window is FM_BASE..FM_BASE+3.
REQ-004 SHALL have parameter MPU_BASE, default 16'h0330, MPU-401 window base; window is MPU_BASE..MPU_BASE+1.
REQ-005 SHALL have port clk_sys, input, 1, sole clock; one clock, and all logic is clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have ports SA, input, 16; BALE, input, 1; AEN, input, 1; IOR_N, input, 1; IOW_N, input, 1; SBHE, input, 1 (active-low); SD_IN, input, 16. All are raw asynchronous ISA signals.
REQ-008 SHALL have output io_addr, 16, latched I/O address.
REQ-009 SHALL have outputs joy_cs, sb_cs, fm_cs and mpu_cs, 1 bit each, registered window decodes.
REQ-010 SHALL have outputs rd_strobe and wr_strobe, 1 bit each, single-cycle command pulses.
REQ-011 SHALL have output wr_data, 8, byte-lane-steered write data.
REQ-012 SHALL have output sd_drive, 1, the enable that drives SD and pulls SD70_DIR/SD158_DIR low.
REQ-013 SHALL have output cmd_err, 1, sticky error on a simultaneous IOR/IOW.

Function
REQ-014 SHALL pass every ISA control input (BALE, AEN, IOR_N, IOW_N) through a 2-flop synchronizer; SA, SD_IN and SBHE SHALL be registered once.
REQ-015 SHALL latch io_addr from registered SA on a synchronized BALE falling edge; io_addr SHALL hold its value otherwise.
REQ-016 SHALL update the cs outputs the cycle after io_addr changes; a cs output SHALL be 0 whenever synchronized AEN is 1, and at most one cs SHALL be 1 at a time.
REQ-017 SHALL implement an FSM with states IDLE, READ, WRITE and ERR.
REQ-018 IDLE->READ SHALL occur on synchronized IOR_N low with IOW_N high; rd_strobe SHALL pulse for exactly 1 cycle on entry when any cs is 1.
REQ-019 IDLE->WRITE SHALL occur on synchronized IOW_N low with IOR_N high; SD_IN SHALL be sampled every cycle in WRITE.
REQ-020 WRITE->IDLE SHALL occur on IOW_N rising; wr_strobe SHALL pulse for exactly 1 cycle on that transition when any cs is 1; wr_data SHALL be the last sample taken before the rising edge.
REQ-021 wr_data SHALL be SD[15:8] when SBHE=0 and io_addr[0]=1, and SD[7:0] otherwise.
REQ-022 READ->IDLE SHALL occur on IOR_N rising; sd_drive SHALL equal (state==READ and any cs and !AEN), and SHALL drop in the same cycle as the exit.
REQ-023 IOR_N and IOW_N both low in any state SHALL go to ERR, set cmd_err, and produce no strobe; ERR->IDLE SHALL occur only when both are high.
REQ-024 A strobe SHALL never be issued while synchronized AEN=1 (DMA cycle), including when AEN rises mid-command.
REQ-025 Latency from an ISA edge to its strobe SHALL be 3 clk_sys cycles without the filter and 4 with it.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, io_addr=0, all cs=0, rd_strobe=0, wr_strobe=0, wr_data=0, sd_drive=0, cmd_err=0, and synchronizers loaded with inactive levels (IOR_N/IOW_N=1, BALE=0, AEN=1).
REQ-027 Reset asserted mid-command SHALL abort the command with no strobe; after release, a command already in progress SHALL be ignored until both strobes are seen high.

Configuration
REQ-028 With ISA_GLITCH_FILTER_EN defined, IOR_N and IOW_N SHALL pass through a 3-sample majority filter after synchronization, and a low pulse of 1 clk_sys cycle SHALL produce no strobe; without the macro there SHALL be no filter, and any synchronized low of at least 1 cycle SHALL count.

Structure
REQ-029 The address defaults and the FSM state enum SHALL live in shared package isa_pkg.
REQ-030 One sub-module, isa_sync (a parameterised N-stage synchronizer with reset value), SHALL be instantiated once per control input.

Verification
REQ-031 Write of 8'h5A to 16'h0388 with SBHE=1: fm_cs=1, one wr_strobe, wr_data=8'h5A, and no rd_strobe.
REQ-032 Write to 16'h0389 with SBHE=0 and SD=16'hA5xx: wr_data=8'hA5.
REQ-033 Read at 16'h0331: mpu_cs=1, rd_strobe pulses 3 cycles after IOR_N falls (4 with the filter), and sd_drive is high exactly while in READ.
REQ-034 Write to 16'h0220 with AEN=1: no cs, no strobe, and sd_drive=0 throughout.
REQ-035 IOR_N and IOW_N low together: cmd_err=1, no strobes, and the next normal write to 16'h0226 is accepted.
REQ-036 With ISA_GLITCH_FILTER_EN, a 1-cycle IOW_N low pulse produces no wr_strobe; rst_n asserted mid-write produces no strobe.
